// File: rtl/pulse_train_if.sv
// Control and status bundle for pulse_train: sequence request/config in, pulse and status out.
interface pulse_train_if #(
  parameter int W = 8
);
  logic         start;
  logic         stop;
  logic [1:0]   mode;
  logic [W-1:0] high_len;
  logic [W-1:0] low_len;
  logic [W-1:0] burst_cnt;
  logic         signal;
  logic         busy;
  logic         done;

  modport master (
    output start, stop, mode, high_len, low_len, burst_cnt,
    input  signal, busy, done
  );

  modport slave (
    input  start, stop, mode, high_len, low_len, burst_cnt,
    output signal, busy, done
  );
endinterface

// File: rtl/pulse_train.sv
// One-shot / periodic / burst pulse generator; config latched at start, signal rises one cycle after start.
// stop aborts at the sampling edge; done strobes once on every return to IDLE except via reset.
module pulse_train #(
  parameter int W = 8
) (
  input logic          clock,
  input logic          reset_n,
  pulse_train_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_BURST    = 2'b10;

  logic [1:0]   state, state_nxt;
  logic [1:0]   mode_q;
  logic [W-1:0] hl_q, ll_q;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] left, left_nxt;
  logic         sig_q;
  logic         done_q;
  logic         accept;
  logic         cnt_last;

  // Zero lengths/counts behave as one.
  function automatic logic [W-1:0] nz(input logic [W-1:0] v);
    return (v == '0) ? W'(1) : v;
  endfunction

  assign accept   = (state == IDLE) && bus.start && !bus.stop;
  assign cnt_last = (cnt == W'(1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    left_nxt  = left;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = HIGH;
          cnt_nxt   = nz(bus.high_len);
          left_nxt  = nz(bus.burst_cnt);
        end
      end
      HIGH: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (cnt_last) begin
          case (mode_q)
            MODE_PERIODIC: begin
              state_nxt = LOW;
              cnt_nxt   = ll_q;
            end
            MODE_BURST: begin
              // The final pulse of a burst has no trailing LOW phase.
              if (left == W'(1)) begin
                state_nxt = IDLE;
              end else begin
                state_nxt = LOW;
                cnt_nxt   = ll_q;
                left_nxt  = left - W'(1);
              end
            end
            default: state_nxt = IDLE;
          endcase
        end else begin
          cnt_nxt = cnt - W'(1);
        end
      end
      LOW: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (cnt_last) begin
          state_nxt = HIGH;
          cnt_nxt   = hl_q;
        end else begin
          cnt_nxt = cnt - W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      mode_q <= '0;
      hl_q   <= '0;
      ll_q   <= '0;
      cnt    <= '0;
      left   <= '0;
      sig_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      left   <= left_nxt;
      sig_q  <= (state_nxt == HIGH);
      done_q <= (state != IDLE) && (state_nxt == IDLE);
      if (accept) begin
        mode_q <= bus.mode;
        hl_q   <= nz(bus.high_len);
        ll_q   <= nz(bus.low_len);
      end
    end
  end

  assign bus.signal = sig_q;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_pulse_train.sv
// Directed bench for pulse_train: a cycle-position model checked every cycle, plus literal traces.
module tb_pulse_train;
  localparam int W = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  bit   chk_en  = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  pulse_train_if #(.W(W)) bus ();

  pulse_train #(.W(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sequence position t since the start edge; signal is high while t mod (h+l) < h.
  bit m_act, m_done;
  int m_t, m_len, m_h, m_l;

  function automatic int nz(input logic [W-1:0] v);
    return (v == 0) ? 1 : int'(v);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_act = 0; m_done = 0; m_t = 0; m_len = 0; m_h = 1; m_l = 1;
    end else if (!m_act) begin
      m_done = 0;
      if (bus.start && !bus.stop) begin
        m_h = nz(bus.high_len);
        m_l = nz(bus.low_len);
        case (bus.mode)
          2'b01:   m_len = -1;
          2'b10:   m_len = nz(bus.burst_cnt) * (m_h + m_l) - m_l;
          default: m_len = m_h;
        endcase
        m_act = 1;
        m_t   = 0;
      end
    end else if (bus.stop) begin
      m_act = 0; m_done = 1;
    end else begin
      m_t++;
      m_done = 0;
      if (m_len >= 0 && m_t >= m_len) begin
        m_act = 0; m_done = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en && reset_n) begin
      chk("model_signal", 32'(bus.signal), 32'(m_act && ((m_t % (m_h + m_l)) < m_h)));
      chk("model_busy",   32'(bus.busy),   32'(m_act));
      chk("model_done",   32'(bus.done),   32'(m_done));
    end
  end

  // Inputs are applied at a negedge; the following n negedges are sampled into traces.
  task automatic launch(input logic [1:0] md, input int h, input int l, input int b, input logic stp);
    @(negedge clock);
    bus.start = 1'b1; bus.stop = stp; bus.mode = md;
    bus.high_len = W'(h); bus.low_len = W'(l); bus.burst_cnt = W'(b);
  endtask

  task automatic capture(input int n, input int stop_at, input int start_at, input bit perturb,
                         output logic [31:0] sig, output logic [31:0] dn, output int busy_n);
    sig = '0; dn = '0; busy_n = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      sig = {sig[30:0], bus.signal};
      dn  = {dn[30:0], bus.done};
      if (bus.busy) busy_n++;
      bus.stop  = (i == stop_at);
      bus.start = (i == start_at);
      if (perturb && bus.busy) begin
        bus.start     = 1'($urandom);
        bus.mode      = 2'($urandom);
        bus.high_len  = W'($urandom);
        bus.low_len   = W'($urandom);
        bus.burst_cnt = W'($urandom);
      end
    end
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  logic [31:0] sig, dn;
  int          bn;

  initial begin
    bus.start = 0; bus.stop = 0; bus.mode = 0;
    bus.high_len = 0; bus.low_len = 0; bus.burst_cnt = 0;
    repeat (2) @(negedge clock);
    chk("reset_signal", 32'(bus.signal), 0);
    chk("reset_busy",   32'(bus.busy),   0);
    chk("reset_done",   32'(bus.done),   0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // one-shot, high_len=3
    launch(2'b00, 3, 7, 0, 0);
    capture(6, -1, -1, 0, sig, dn, bn);
    chk("oneshot_sig", sig, 32'b111000);
    chk("oneshot_done", dn, 32'b000100);
    chk("oneshot_busy", 32'(bn), 3);

    // periodic 2/3, stop in second LOW cycle of the second period
    launch(2'b01, 2, 3, 0, 0);
    capture(11, 8, -1, 0, sig, dn, bn);
    chk("periodic_sig", sig, 32'b11000110000);
    chk("periodic_done", dn, 32'b00000000010);
    chk("periodic_busy", 32'(bn), 9);

    // burst 1/2 x4, with start pulses and config churn while busy
    launch(2'b10, 1, 2, 4, 0);
    capture(12, -1, -1, 1, sig, dn, bn);
    chk("burst_sig", sig, 32'b100100100100);
    chk("burst_done", dn, 32'b000000000010);
    chk("burst_busy", 32'(bn), 10);

    // zero lengths collapse to a single one-cycle pulse
    launch(2'b10, 0, 0, 0, 0);
    capture(4, -1, -1, 0, sig, dn, bn);
    chk("zero_sig", sig, 32'b1000);
    chk("zero_done", dn, 32'b0100);

    // start together with stop in IDLE does nothing
    launch(2'b01, 2, 2, 0, 1);
    capture(3, -1, -1, 0, sig, dn, bn);
    chk("startstop_sig", sig, 0);
    chk("startstop_done", dn, 0);
    chk("startstop_busy", 32'(bn), 0);

    // restart during the done cycle, reserved mode behaves as one-shot
    launch(2'b11, 1, 5, 0, 0);
    capture(5, -1, 1, 0, sig, dn, bn);
    chk("b2b_sig", sig, 32'b10100);
    chk("b2b_done", dn, 32'b01010);

    // maximum length, no wrap
    launch(2'b00, 255, 0, 0, 0);
    capture(258, -1, -1, 0, sig, dn, bn);
    chk("maxlen_busy", 32'(bn), 255);
    chk("maxlen_done", dn, 32'b0100);

    // async reset mid-HIGH, between edges
    launch(2'b00, 5, 0, 0, 0);
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_signal", 32'(bus.signal), 0);
    chk("arst_busy",   32'(bus.busy),   0);
    chk("arst_done",   32'(bus.done),   0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("arst_no_done", 32'(bus.done), 0);
    launch(2'b00, 2, 0, 0, 0);
    capture(4, -1, -1, 0, sig, dn, bn);
    chk("post_reset_sig", sig, 32'b1100);
    chk("post_reset_done", dn, 32'b0010);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pulse_train.md
PULSE_TRAIN -- requirements
Module: pulse_train

Interface
REQ-001 SHALL have parameter W, default 8, bit width of all length/count inputs and internal counters.
REQ-002 SHALL have port clock  input  1  single clock; all state changes on posedge clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a pulse sequence; sampled on posedge.
REQ-005 SHALL have port stop  input  1  request to abort an active sequence; sampled on posedge.
REQ-006 SHALL have port mode  input  2  00 one-shot, 01 periodic, 10 burst, 11 reserved.
REQ-007 SHALL have port high_len  input  W  cycles signal is high per pulse.
REQ-008 SHALL have port low_len  input  W  cycles signal is low between pulses.
REQ-009 SHALL have port burst_cnt  input  W  pulses per burst (burst mode only).
REQ-010 SHALL have port signal  output  1  registered pulse output.
REQ-011 SHALL have port busy  output  1  high while state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle strobe on return to IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, HIGH, LOW; signal SHALL equal 1 exactly when state is HIGH.
REQ-014 SHALL, in IDLE with start=1 and stop=0 at a posedge, latch mode, high_len, low_len, burst_cnt and enter HIGH; signal rises one cycle after the sampling edge.
REQ-015 SHALL ignore input changes to mode/lengths/count while busy; latched copies govern the whole sequence.
REQ-016 SHALL treat a latched high_len, low_len or burst_cnt of 0 as 1.
REQ-017 SHALL hold HIGH for exactly high_len cycles and LOW for exactly low_len cycles, using down-counters of width W (max 2^W-1 cycles, no wrap).
REQ-018 One-shot (00) and reserved (11): HIGH -> IDLE after high_len cycles; no LOW phase.
REQ-019 Periodic (01): HIGH -> LOW -> HIGH indefinitely until stop; period high_len+low_len cycles.
REQ-020 Burst (10): emit burst_cnt pulses separated by LOW phases; after the last HIGH go directly to IDLE (no trailing LOW).
REQ-021 SHALL, when stop=1 at a posedge in HIGH or LOW, enter IDLE at that edge with signal=0, regardless of mode or remaining count.
REQ-022 SHALL assert done for exactly one cycle in the first IDLE cycle after any exit from HIGH/LOW (normal completion or stop).
REQ-023 SHALL ignore start while busy (no restart, no extension).
REQ-024 SHALL, with start=1 and stop=1 in IDLE, remain in IDLE (stop wins); no done strobe.
REQ-025 SHALL allow start in the cycle done=1 (IDLE) to begin a new sequence immediately, giving one idle cycle between sequences.
REQ-026 busy SHALL be 1 in HIGH and LOW, 0 in IDLE.

Reset
REQ-027 SHALL, on reset_n=0, immediately (asynchronously) force state=IDLE, signal=0, busy=0, done=0, all counters and latched config to 0.
REQ-028 SHALL, on reset_n=0 mid-sequence, abort without a done strobe; after reset_n returns high, the first start is accepted normally.

Verification
REQ-029 One-shot: mode=00, high_len=3, start 1 cycle -> signal high 3 cycles starting 1 cycle after start, then done=1 for 1 cycle, busy low.
REQ-030 Periodic + stop: mode=01, high_len=2, low_len=3 -> pattern 11000 repeating; stop asserted in 2nd LOW cycle -> signal 0, IDLE next cycle, done=1 once.
REQ-031 Burst: mode=10, high_len=1, low_len=2, burst_cnt=4 -> 4 pulses 1001001001, total 10 busy cycles, done after last high.
REQ-032 Zero lengths: mode=10, high_len=0, low_len=0, burst_cnt=0 -> exactly one 1-cycle pulse then done.
REQ-033 Conflicts: start+stop together in IDLE -> no activity; start pulsed while busy -> sequence unchanged; config inputs changed while busy -> no effect.
REQ-034 Async reset: reset_n low mid-HIGH (between edges) -> signal, busy 0 immediately, done never asserted; release then start -> normal sequence.
